preta_xform_pipe: RTL and testbench

//  Parametrised, pipelined Winograd input-transform engine for the PRETA datapath.

---
 rtl/preta_xform_pkg.sv | 51 +++++
 rtl/preta_xform_pipe_bt_1d.sv | 38 +++
 rtl/preta_xform_pipe.sv | 158 +++++++++++++++
 tb/tb_preta_xform_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preta_xform_pkg.sv
// Shared types, Winograd input-transform matrices and the output clamp
// helper for the PRETA transform pipeline.
package preta_xform_pkg;

    typedef enum logic {
        MODE_DECONV = 1'b0,
        MODE_CONV   = 1'b1
    } xform_mode_t;

    localparam logic signed [1:0] BT_P = 2'sb01;
    localparam logic signed [1:0] BT_N = 2'sb11;
    localparam logic signed [1:0] BT_Z = 2'sb00;

    localparam logic signed [1:0] BT_DECONV [6][4] = '{
        '{BT_P, BT_N, BT_Z, BT_Z},
        '{BT_Z, BT_P, BT_Z, BT_Z},
        '{BT_Z, BT_N, BT_P, BT_Z},
        '{BT_Z, BT_P, BT_N, BT_Z},
        '{BT_Z, BT_Z, BT_P, BT_Z},
        '{BT_Z, BT_Z, BT_N, BT_P}
    };

    // Rows 4-5 are zero so Conv results come out already zero-padded to 6x6.
    localparam logic signed [1:0] BT_CONV [6][4] = '{
        '{BT_P, BT_Z, BT_N, BT_Z},
        '{BT_Z, BT_P, BT_P, BT_Z},
        '{BT_Z, BT_N, BT_P, BT_Z},
        '{BT_Z, BT_P, BT_Z, BT_N},
        '{BT_Z, BT_Z, BT_Z, BT_Z},
        '{BT_Z, BT_Z, BT_Z, BT_Z}
    };

    // Clamp a sign-extended value into the signed range of an out_w-bit word.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] value,
                                                     input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (out_w >= 64) begin
            return value;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/preta_xform_pipe_bt_1d.sv
// One-dimensional BT transform: 4 signed samples -> 6 signed results, one bit
// wider, built from the +-1 coefficient tables with add/sub only.
module preta_bt_1d
    import preta_xform_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [4*W-1:0]     i_x,
    input  xform_mode_t        i_mode,
    output logic [6*(W+1)-1:0] o_y
);

    logic signed [W:0]   w_acc;
    logic signed [W:0]   w_xe;
    logic signed [1:0]   w_coef;

    // Coefficients are constants per mode, so each row folds to at most one add or sub.
    always_comb begin
        o_y    = '0;
        w_acc  = '0;
        w_xe   = '0;
        w_coef = BT_Z;
        for (int r = 0; r < 6; r++) begin
            w_acc = '0;
            for (int c = 0; c < 4; c++) begin
                w_coef = (i_mode == MODE_CONV) ? BT_CONV[r][c] : BT_DECONV[r][c];
                w_xe   = {i_x[c*W + W - 1], i_x[c*W +: W]};
                if (w_coef == BT_P) begin
                    w_acc = w_acc + w_xe;
                end else if (w_coef == BT_N) begin
                    w_acc = w_acc - w_xe;
                end
            end
            o_y[r*(W+1) +: (W+1)] = w_acc;
        end
    end

endmodule

// File: rtl/preta_xform_pipe.sv
// Two-stage Winograd input transform (BT * d * BT^T) over LANES patches per
// beat, with valid/ready backpressure, output clamping and mode/last passthrough.
module preta_xform_pipe
    import preta_xform_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int OUT_W  = DATA_W + 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_mode,
    input  logic                          in_last,
    input  logic [LANES*4*4*DATA_W-1:0]   in_patch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_mode,
    output logic                          out_last,
    output logic [LANES*6*6*OUT_W-1:0]    out_patch,
    output logic [LANES-1:0]              out_sat
);

    localparam int T_W = DATA_W + 1;
    localparam int F_W = DATA_W + 2;
    localparam int NT  = LANES * 6 * 4;
    localparam int NO  = LANES * 6 * 6;

    logic              r_s1_v;
    logic              r_s2_v;
    logic [NT*T_W-1:0] r_s1_t;
    xform_mode_t       r_s1_mode;
    logic              r_s1_last;
    logic [NO*OUT_W-1:0] r_s2_patch;
    logic [LANES-1:0]  r_s2_sat;
    xform_mode_t       r_s2_mode;
    logic              r_s2_last;

    logic              w_adv2;
    logic              w_acc;
    logic [NT*T_W-1:0] w_t;
    logic [NO*F_W-1:0] w_full;
    logic [NO*OUT_W-1:0] w_clip;
    logic [LANES-1:0]  w_sat;
    logic signed [63:0] w_ext;
    logic signed [63:0] w_lim;

    // Stage 2 advances when it is empty or its beat is leaving; stage 1 refills behind it.
    assign w_adv2   = r_s1_v & (~r_s2_v | out_ready);
    assign in_ready = ~r_s1_v | w_adv2;
    assign w_acc    = in_valid & in_ready;

    // Stage 1 column transforms: T[l][*][c] = BT * d[l][*][c].
    for (genvar l = 0; l < LANES; l++) begin : g_s1_lane
        for (genvar c = 0; c < 4; c++) begin : g_s1_col
            logic [4*DATA_W-1:0] w_cin;
            logic [6*T_W-1:0]    w_cout;
            for (genvar r = 0; r < 4; r++) begin : g_in
                assign w_cin[r*DATA_W +: DATA_W] = in_patch[((l*4 + r)*4 + c)*DATA_W +: DATA_W];
            end
            preta_bt_1d #(.W(DATA_W)) u_bt (
                .i_x    (w_cin),
                .i_mode (xform_mode_t'(in_mode)),
                .o_y    (w_cout)
            );
            for (genvar r = 0; r < 6; r++) begin : g_out
                assign w_t[((l*6 + r)*4 + c)*T_W +: T_W] = w_cout[r*T_W +: T_W];
            end
        end
    end

    // Stage 2 row transforms: out[l][r][*] = T[l][r][*] * BT^T.
    for (genvar l = 0; l < LANES; l++) begin : g_s2_lane
        for (genvar r = 0; r < 6; r++) begin : g_s2_row
            logic [4*T_W-1:0] w_rin;
            logic [6*F_W-1:0] w_rout;
            for (genvar c = 0; c < 4; c++) begin : g_in
                assign w_rin[c*T_W +: T_W] = r_s1_t[((l*6 + r)*4 + c)*T_W +: T_W];
            end
            preta_bt_1d #(.W(T_W)) u_bt (
                .i_x    (w_rin),
                .i_mode (r_s1_mode),
                .o_y    (w_rout)
            );
            for (genvar j = 0; j < 6; j++) begin : g_out
                assign w_full[((l*6 + r)*6 + j)*F_W +: F_W] = w_rout[j*F_W +: F_W];
            end
        end
    end

    // Full-precision results are exact; clamping only bites when OUT_W < DATA_W+2.
    always_comb begin
        w_clip = '0;
        w_sat  = '0;
        w_ext  = '0;
        w_lim  = '0;
        for (int e = 0; e < NO; e++) begin
            w_ext = {{(64 - F_W){w_full[e*F_W + F_W - 1]}}, w_full[e*F_W +: F_W]};
            w_lim = sat_clip(w_ext, OUT_W);
            w_clip[e*OUT_W +: OUT_W] = w_lim[OUT_W-1:0];
            if (w_lim != w_ext) begin
                w_sat[e / 36] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
        end else begin
            if (w_acc) begin
                r_s1_v <= 1'b1;
            end else if (w_adv2) begin
                r_s1_v <= 1'b0;
            end
            if (w_adv2) begin
                r_s2_v <= 1'b1;
            end else if (out_ready) begin
                r_s2_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_t    <= '0;
            r_s1_mode <= MODE_DECONV;
            r_s1_last <= 1'b0;
        end else if (w_acc) begin
            r_s1_t    <= w_t;
            r_s1_mode <= xform_mode_t'(in_mode);
            r_s1_last <= in_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_patch <= '0;
            r_s2_sat   <= '0;
            r_s2_mode  <= MODE_DECONV;
            r_s2_last  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_patch <= w_clip;
            r_s2_sat   <= w_sat;
            r_s2_mode  <= r_s1_mode;
            r_s2_last  <= r_s1_last;
        end
    end

    assign out_valid = r_s2_v;
    assign out_patch = r_s2_patch;
    assign out_sat   = r_s2_sat;
    assign out_mode  = r_s2_mode;
    assign out_last  = r_s2_last;

endmodule

// File: tb/tb_preta_xform_pipe.sv
// Bench for preta_xform_pipe: a full-width and a clamped (OUT_W=16) instance
// share stimulus; outputs are checked against a matrix-product reference model.
module tb_preta_xform_pipe;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int WW    = DW + 2;
    localparam int NW    = 16;
    localparam int PW    = LANES * 16 * DW;
    localparam int OWW   = LANES * 36 * WW;
    localparam int ONW   = LANES * 36 * NW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_mode = 1'b0;
    logic           in_last = 1'b0;
    logic [PW-1:0]  in_patch = '0;
    logic           out_ready = 1'b1;

    logic           in_ready, out_valid, out_mode, out_last;
    logic [OWW-1:0] out_patch_w;
    logic [LANES-1:0] out_sat_w;
    logic           in_ready_n, out_valid_n, out_mode_n, out_last_n;
    logic [ONW-1:0] out_patch_n;
    logic [LANES-1:0] out_sat_n;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_out = 0;

    always #5 clk = ~clk;

    preta_xform_pipe #(.LANES(LANES), .DATA_W(DW), .OUT_W(WW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_last(in_last), .in_patch(in_patch),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_last(out_last), .out_patch(out_patch_w), .out_sat(out_sat_w)
    );

    preta_xform_pipe #(.LANES(LANES), .DATA_W(DW), .OUT_W(NW)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_mode(in_mode), .in_last(in_last), .in_patch(in_patch),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_mode(out_mode_n),
        .out_last(out_last_n), .out_patch(out_patch_n), .out_sat(out_sat_n)
    );

    // Reference transform matrices, written out independently of the design.
    int btd [6][4] = '{'{1,-1,0,0}, '{0,1,0,0}, '{0,-1,1,0}, '{0,1,-1,0}, '{0,0,1,0}, '{0,0,-1,1}};
    int btc [6][4] = '{'{1,0,-1,0}, '{0,1,1,0}, '{0,-1,1,0}, '{0,1,0,-1}, '{0,0,0,0}, '{0,0,0,0}};

    typedef struct {
        logic          mode;
        logic          last;
        logic [PW-1:0] patch;
    } beat_t;
    beat_t sb_q[$];

    typedef struct {
        logic mode;
        int   lane;
        int   ones;
        int   ir, ic, val;
        int   ci, cj;
        int   exp_w, exp_n, exp_sat;
    } vec_t;
    vec_t vt[13];

    function automatic int d_at(logic [PW-1:0] p, int l, int r, int c);
        logic signed [DW-1:0] v;
        v = p[((l*4 + r)*4 + c)*DW +: DW];
        return int'(v);
    endfunction

    // out = BT * d * BT^T evaluated directly as a double sum.
    function automatic int model_elem(logic mode, logic [PW-1:0] p, int l, int i, int j);
        int acc = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (mode) acc += btc[i][r] * d_at(p, l, r, c) * btc[j][c];
                else      acc += btd[i][r] * d_at(p, l, r, c) * btd[j][c];
            end
        end
        return acc;
    endfunction

    function automatic int clip_n(int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int elem_w(int l, int i, int j);
        logic signed [WW-1:0] v;
        v = out_patch_w[((l*6 + i)*6 + j)*WW +: WW];
        return int'(v);
    endfunction

    function automatic int elem_n(int l, int i, int j);
        logic signed [NW-1:0] v;
        v = out_patch_n[((l*6 + i)*6 + j)*NW +: NW];
        return int'(v);
    endfunction

    function automatic logic [PW-1:0] rand_patch();
        logic [PW-1:0] p;
        logic signed [DW-1:0] s;
        p = '0;
        for (int e = 0; e < LANES*16; e++) begin
            if ($urandom_range(0, 1) == 0) s = DW'($urandom_range(0, 65535));
            else s = DW'(int'($urandom_range(0, 40)) - 20);
            p[e*DW +: DW] = s;
        end
        return p;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each emitted beat is checked against the oldest accepted one.
    always @(negedge clk) begin
        beat_t b;
        logic [36*WW-1:0] ew;
        logic [36*NW-1:0] en;
        logic esat;
        int v, cv;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: output beat with nothing expected at %0t", $time);
                end else begin
                    b = sb_q.pop_front();
                    check_int("out_mode", out_mode, b.mode);
                    check_int("out_last", out_last, b.last);
                    check_int("out_valid_n", out_valid_n, 1);
                    for (int l = 0; l < LANES; l++) begin
                        esat = 1'b0;
                        for (int i = 0; i < 6; i++) begin
                            for (int j = 0; j < 6; j++) begin
                                v  = model_elem(b.mode, b.patch, l, i, j);
                                cv = clip_n(v);
                                ew[(i*6 + j)*WW +: WW] = WW'(v);
                                en[(i*6 + j)*NW +: NW] = NW'(cv);
                                if (cv != v) esat = 1'b1;
                            end
                        end
                        total++;
                        if (out_patch_w[l*36*WW +: 36*WW] !== ew) begin
                            bad++;
                            $display("FAIL patch_w lane %0d: got %h expected %h", l, out_patch_w[l*36*WW +: 36*WW], ew);
                        end
                        total++;
                        if (out_patch_n[l*36*NW +: 36*NW] !== en) begin
                            bad++;
                            $display("FAIL patch_n lane %0d: got %h expected %h", l, out_patch_n[l*36*NW +: 36*NW], en);
                        end
                        check_int("sat_n", out_sat_n[l], esat);
                        check_int("sat_w", out_sat_w[l], 0);
                    end
                end
            end
            if (in_valid && in_ready) begin
                b.mode  = in_mode;
                b.last  = in_last;
                b.patch = in_patch;
                sb_q.push_back(b);
                n_acc++;
            end
        end
    end

    // Holds a beat on the input until it is taken; returns just after the accepting edge.
    task automatic send_beat(input logic m, input logic lst, input logic [PW-1:0] p);
        int  n;
        bit  got;
        in_valid = 1'b1;
        in_mode  = m;
        in_last  = lst;
        in_patch = p;
        got = 1'b0;
        n   = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            n++;
        end
        #1 in_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_int("drain_left", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0]  p;
        logic [OWW-1:0] snap_w;
        logic           snap_last;
        bit             have;
        bit             done;
        int             a0, o0, so;

        // Directed vectors: mode, lane, ones?, impulse r/c/val, checked element, expectations
        vt[0]  = '{1'b0, 0, 1, 0, 0, 0,      1, 1, 1, 1, 0};
        vt[1]  = '{1'b0, 0, 1, 0, 0, 0,      1, 4, 1, 1, 0};
        vt[2]  = '{1'b0, 0, 1, 0, 0, 0,      0, 0, 0, 0, 0};
        vt[3]  = '{1'b0, 2, 1, 0, 0, 0,      4, 4, 1, 1, 0};
        vt[4]  = '{1'b0, 1, 0, 1, 1, 5,      0, 0, 5, 5, 0};
        vt[5]  = '{1'b0, 1, 0, 1, 1, 5,      0, 1, -5, -5, 0};
        vt[6]  = '{1'b0, 1, 0, 1, 1, 5,      3, 3, 5, 5, 0};
        vt[7]  = '{1'b0, 1, 0, 1, 1, 5,      4, 2, 0, 0, 0};
        vt[8]  = '{1'b1, 3, 1, 0, 0, 0,      1, 1, 4, 4, 0};
        vt[9]  = '{1'b1, 0, 1, 0, 0, 0,      4, 4, 0, 0, 0};
        vt[10] = '{1'b1, 1, 0, 2, 2, 7,      1, 2, 7, 7, 0};
        vt[11] = '{1'b0, 2, 0, 1, 1, -32768, 0, 1, 32768, 32767, 1};
        vt[12] = '{1'b0, 2, 0, 1, 1, -32768, 0, 0, -32768, -32768, 1};

        // Reset state
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_int("rst_out_valid", out_valid, 0);
        check_int("rst_in_ready", in_ready, 1);
        check_int("rst_patch_nz", (out_patch_w != '0) || (out_patch_n != '0), 0);
        check_int("rst_sat", int'(out_sat_n), 0);
        check_int("rst_mode", out_mode, 0);
        check_int("rst_last", out_last, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven single beats with latency check
        for (int t = 0; t < 13; t++) begin
            p = '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (vt[t].ones != 0)
                        p[((vt[t].lane*4 + r)*4 + c)*DW +: DW] = DW'(1);
                    else if (r == vt[t].ir && c == vt[t].ic)
                        p[((vt[t].lane*4 + r)*4 + c)*DW +: DW] = DW'(vt[t].val);
                end
            end
            send_beat(vt[t].mode, 1'b0, p);
            @(negedge clk);
            check_int("lat_early", out_valid, 0);
            @(negedge clk);
            check_int("lat_on", out_valid, 1);
            check_int("vec_w", elem_w(vt[t].lane, vt[t].ci, vt[t].cj), vt[t].exp_w);
            check_int("vec_n", elem_n(vt[t].lane, vt[t].ci, vt[t].cj), vt[t].exp_n);
            check_int("vec_sat", out_sat_n[vt[t].lane], vt[t].exp_sat);
            so = 0;
            for (int l = 0; l < LANES; l++) if (l != vt[t].lane && out_sat_n[l]) so++;
            check_int("vec_sat_other", so, 0);
            check_int("vec_mode", out_mode, vt[t].mode);
            @(posedge clk);
            #1;
        end

        // Back-to-back beats with alternating mode
        for (int k = 0; k < 6; k++) send_beat(k[0], k == 5, rand_patch());
        drain();

        // Stall: downstream blocked for 6 cycles while 5 beats are offered
        a0 = n_acc;
        o0 = n_out;
        have = 1'b0;
        snap_w = '0;
        snap_last = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) send_beat(k[0], k == 4, rand_patch());
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (!have) begin
                            snap_w = out_patch_w;
                            snap_last = out_last;
                            have = 1'b1;
                        end else begin
                            check_int("stall_stable", (out_patch_w !== snap_w) || (out_last !== snap_last), 0);
                        end
                    end
                end
                check_int("stall_accepted", n_acc - a0, 2);
                check_int("stall_in_ready", in_ready, 0);
                check_int("stall_out_valid", out_valid, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check_int("stall_emitted", n_out - o0, 5);

        // Randomised traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send_beat(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 7) == 0)), rand_patch());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight
        o0 = n_out;
        send_beat(1'b0, 1'b1, rand_patch());
        send_beat(1'b1, 1'b1, rand_patch());
        #1 rst = 1'b1;
        #1;
        check_int("rst_flight_valid", out_valid, 0);
        check_int("rst_flight_ready", in_ready, 1);
        check_int("rst_flight_patch_nz", out_patch_w != '0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_int("post_rst_valid", out_valid, 0);
        send_beat(1'b1, 1'b0, rand_patch());
        drain();
        check_int("post_rst_count", n_out - o0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
